// File: rtl/imem_fetch_sequencer.sv
// Fetch sequencer for a 1-cycle-latency word-addressed instruction memory.
// Tracks one in-flight read and buffers returns in a 2-entry queue toward decode.
module imem_fetch_sequencer #(
  parameter int            AW       = 13,
  parameter int            DW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          halt,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_instr,
  output logic [AW-1:0] out_pc,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
  } entry_t;

  state_t        state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]    count_q, count_nx;
  logic          head_q, tail_q;
  entry_t        q_mem [2];

  logic       pop, push, redir;
  logic [2:0] occ;

  assign redir    = redirect_valid && (state_q == RUN);
  assign mem_addr = redir ? redirect_pc : fetch_pc_q;
  assign pop      = (count_q != 2'd0) && out_ready;
  // A redirect kills the word returning this cycle: it belongs to the old path.
  assign push     = inflight_q && !redir;
  // Occupancy once this cycle's return lands; a new issue needs a free slot next cycle.
  assign occ      = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign count_nx = redir ? 2'd0 : (count_q + {1'b0, push} - {1'b0, pop});

  assign out_valid = (count_q != 2'd0);
  assign out_instr = q_mem[head_q].instr;
  assign out_pc    = q_mem[head_q].pc;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          fetch_pc_d = RESET_PC;
        end
      end
      RUN: begin
        if (halt) begin
          state_d = DRAIN;
          if (redir) fetch_pc_d = redirect_pc;
        end else if (redir || (occ < 3'd2)) begin
          inflight_d    = 1'b1;
          inflight_pc_d = mem_addr;
          fetch_pc_d    = mem_addr + AW'(1);
        end
      end
      DRAIN: begin
        if (!inflight_q && (count_nx == 2'd0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      for (int i = 0; i < 2; i++) q_mem[i] <= '0;
    end else begin
      count_q <= count_nx;
      if (redir) begin
        head_q <= 1'b0;
        tail_q <= 1'b0;
      end else begin
        if (push) begin
          q_mem[tail_q] <= '{instr: mem_rdata, pc: inflight_pc_q};
          tail_q        <= tail_q + 1'b1;
        end
        if (pop) head_q <= head_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed bench for imem_fetch_sequencer: memory word k holds k, expected pcs
// are queued when stimulus is driven and popped as decode accepts words.
module tb_imem_fetch_sequencer;
  localparam int AW = 13;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0, halt = 1'b0, redirect_valid = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [AW-1:0] mem_addr, out_pc;
  logic [DW-1:0] mem_rdata = '0, out_instr;
  logic          out_valid, busy;

  int            n_chk = 0, n_pass = 0, n_pop = 0;
  logic [AW-1:0] exp_q [$];

  imem_fetch_sequencer #(.AW(AW), .DW(DW), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  // Registered-read memory: word k holds k.
  always @(posedge clk) mem_rdata <= DW'(mem_addr);

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_seq(logic [AW-1:0] s, int n);
    logic [AW-1:0] p;
    p = s;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(p);
      p = p + AW'(1);
    end
  endtask

  // Scoreboard: every accepted word must be the next expected pc.
  always @(negedge clk) begin
    logic [AW-1:0] e;
    if (rst_n && out_valid && out_ready) begin
      chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_pc", 32'(out_pc), 32'(e));
        chk("out_instr", out_instr, DW'(e));
        n_pop++;
      end
    end
  end

  initial begin
    logic [AW-1:0] h;
    int n0;

    // Reset state
    #2 rst_n = 1'b0;
    tick(2);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_pc", 32'(out_pc), 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(1);

    // Start: first word two cycles after start is sampled
    push_seq('0, 40);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_valid_c1", 32'(out_valid), 0);
    tick(1);
    chk("start_valid_c2", 32'(out_valid), 0);
    tick(1);
    chk("start_valid_c3", 32'(out_valid), 1);
    chk("start_first_pc", 32'(out_pc), 0);
    tick(8);

    // Back-pressure: queue fills, issue stops, address held
    h = exp_q[0];
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("bp_mem_addr_held", 32'(mem_addr), 32'(h + AW'(2)));
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_pc_stable", 32'(out_pc), 32'(h));
    end
    out_ready = 1'b1;
    tick(6);

    // Redirect with a full queue: stale words flushed
    out_ready = 1'b0;
    tick(3);
    redirect_valid = 1'b1;
    redirect_pc = AW'(13'h100);
    #1 chk("redir_mem_addr", 32'(mem_addr), 32'h100);
    tick(1);
    redirect_valid = 1'b0;
    exp_q.delete();
    push_seq(AW'(13'h100), 20);
    chk("redir_flush_valid", 32'(out_valid), 0);
    tick(1);
    chk("redir_first_valid", 32'(out_valid), 1);
    chk("redir_first_pc", 32'(out_pc), 32'h100);
    out_ready = 1'b1;
    tick(6);

    // Redirect while streaming, with address wrap-around
    redirect_valid = 1'b1;
    redirect_pc = AW'(8190);
    tick(1);
    redirect_valid = 1'b0;
    exp_q.delete();
    push_seq(AW'(8190), 30);
    chk("wrap_flush_valid", 32'(out_valid), 0);
    tick(1);
    chk("wrap_first_valid", 32'(out_valid), 1);
    chk("wrap_first_pc", 32'(out_pc), 8190);
    tick(8);

    // Halt: deliver queued + in-flight words, then idle
    n0 = n_pop;
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    chk("halt_draining_busy", 32'(busy), 1);
    for (int i = 0; i < 10 && busy; i++) tick(1);
    chk("halt_idle", 32'(busy), 0);
    chk("halt_out_valid", 32'(out_valid), 0);
    chk("halt_delivered", 32'(n_pop - n0), 2);

    // Restart from RESET_PC
    exp_q.delete();
    push_seq('0, 20);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    chk("restart_valid", 32'(out_valid), 1);
    chk("restart_pc", 32'(out_pc), 0);
    tick(5);

    // Asynchronous reset between edges
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_out_valid", 32'(out_valid), 0);
    chk("areset_busy", 32'(busy), 0);
    chk("areset_out_pc", 32'(out_pc), 0);
    chk("areset_out_instr", out_instr, 0);
    exp_q.delete();
    tick(1);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("post_reset_no_valid", 32'(out_valid), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
